inagu: RTL and testbench



---
 rtl/inagu.sv | 121 ++++++++++++
 tb/tb_inagu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/inagu.sv
// Input data memory read-address generator.
// A start pulse latches a three-level nested-loop walk (inner/middle/outer)
// with signed strides. Each address is offered on addrout with valid and is
// held while stall is high. A one-cycle done pulse follows the last accepted
// address.
module inagu #(
  parameter int BDBANKA = 15,
  parameter int BCNT    = 10,
  parameter int BJMP    = 15
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [BDBANKA-1:0] baseaddr,
  input  logic [BCNT-1:0]    cnt0,
  input  logic [BCNT-1:0]    cnt1,
  input  logic [BCNT-1:0]    cnt2,
  input  logic [BJMP-1:0]    jump0,
  input  logic [BJMP-1:0]    jump1,
  input  logic [BJMP-1:0]    jump2,
  input  logic               stall,
  output logic [BDBANKA-1:0] addrout,
  output logic               valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [BCNT-1:0]    lim0_reg, lim1_reg, lim2_reg;
  logic [BJMP-1:0]    jump0_reg, jump1_reg, jump2_reg;
  logic [BCNT-1:0]    i0_reg, i1_reg, i2_reg;

  // Jumps sign-extended to the address width. Adding at address width and
  // dropping the carry is the same as a wider add truncated back, so the
  // address simply wraps modulo 2^BDBANKA.
  logic [BDBANKA-1:0] ext0, ext1, ext2;

  for (genvar gi = 0; gi < BDBANKA; gi++) begin : g_sext
    if (gi < BJMP) begin : g_copy
      assign ext0[gi] = jump0_reg[gi];
      assign ext1[gi] = jump1_reg[gi];
      assign ext2[gi] = jump2_reg[gi];
    end else begin : g_sign
      assign ext0[gi] = jump0_reg[BJMP-1];
      assign ext1[gi] = jump1_reg[BJMP-1];
      assign ext2[gi] = jump2_reg[BJMP-1];
    end
  end

  logic accept;
  assign accept = valid & ~stall;

  // Walk controller: launch from IDLE, step the loop nest on each accept,
  // return to IDLE with a done pulse after the final address.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      addrout   <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      i0_reg    <= '0;
      i1_reg    <= '0;
      i2_reg    <= '0;
      lim0_reg  <= '0;
      lim1_reg  <= '0;
      lim2_reg  <= '0;
      jump0_reg <= '0;
      jump1_reg <= '0;
      jump2_reg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lim0_reg  <= cnt0;
            lim1_reg  <= cnt1;
            lim2_reg  <= cnt2;
            jump0_reg <= jump0;
            jump1_reg <= jump1;
            jump2_reg <= jump2;
            addrout   <= baseaddr;
            i0_reg    <= '0;
            i1_reg    <= '0;
            i2_reg    <= '0;
            valid     <= 1'b1;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (i0_reg < lim0_reg) begin
              addrout <= addrout + ext0;
              i0_reg  <= i0_reg + 1'b1;
            end else if (i1_reg < lim1_reg) begin
              addrout <= addrout + ext1;
              i0_reg  <= '0;
              i1_reg  <= i1_reg + 1'b1;
            end else if (i2_reg < lim2_reg) begin
              addrout <= addrout + ext2;
              i0_reg  <= '0;
              i1_reg  <= '0;
              i2_reg  <= i2_reg + 1'b1;
            end else begin
              // Last address accepted: addrout keeps its final value.
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inagu.sv
// Testbench for inagu: fixed vectors from known walks, hand sequences for
// stall / start-interference / clear, and random chained walks checked
// against a closed-form address model.
module tb_inagu;

  logic        clk = 1'b0;
  logic        clr, start, stall;
  logic [14:0] baseaddr;
  logic [9:0]  cnt0, cnt1, cnt2;
  logic [14:0] jump0, jump1, jump2;
  logic [14:0] addrout;
  logic        valid, busy, done;

  always #5 clk = ~clk;

  inagu dut (
    .clk(clk), .clr(clr), .start(start), .baseaddr(baseaddr),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2),
    .jump0(jump0), .jump1(jump1), .jump2(jump2),
    .stall(stall), .addrout(addrout), .valid(valid), .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;
  logic [14:0] exp_q[$];

  typedef struct {
    string       name;
    logic [14:0] base;
    logic [9:0]  c0, c1, c2;
    logic [14:0] j0, j1, j2;
    int          n;
    logic [14:0] e[8];
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  function automatic longint sj(input logic [14:0] j);
    return j[14] ? longint'(j) - 32768 : longint'(j);
  endfunction

  // Closed form: each index step contributes a fixed signed offset, the
  // offset of a middle/outer step being the whole inner/middle span plus
  // the wrap jump.
  task automatic model(input logic [14:0] b, input logic [9:0] c0, c1, c2,
                       input logic [14:0] j0, j1, j2);
    longint s0, s1, s2, a;
    s0 = sj(j0);
    s1 = longint'(c0) * s0 + sj(j1);
    s2 = longint'(c1) * s1 + longint'(c0) * s0 + sj(j2);
    exp_q.delete();
    for (int k2 = 0; k2 <= int'(c2); k2++)
      for (int k1 = 0; k1 <= int'(c1); k1++)
        for (int k0 = 0; k0 <= int'(c0); k0++) begin
          a = longint'(b) + k0 * s0 + k1 * s1 + k2 * s2;
          exp_q.push_back(15'(a & 'h7FFF));
        end
  endtask

  task automatic load_vec(input int v);
    exp_q.delete();
    for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(vecs[v].e[k]);
  endtask

  // Called just after a negedge. smode: 0 no stall, 1 random, 2 stall on
  // the 2nd and 3rd valid cycles. poke re-pulses start mid-walk.
  task automatic run_walk(input string name, input logic [14:0] b,
                          input logic [9:0] c0, c1, c2,
                          input logic [14:0] j0, j1, j2,
                          input int smode, input bit poke, input bit idle_after);
    int n, idx, vcyc, stalls, cyc, budget;
    bit fin, stl;
    n = exp_q.size();
    idx = 0; vcyc = 0; stalls = 0; cyc = 0; fin = 0;
    budget = (n + 1) * 8 + 20;
    baseaddr = b; cnt0 = c0; cnt1 = c1; cnt2 = c2;
    jump0 = j0; jump1 = j1; jump2 = j2;
    stall = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    baseaddr = 15'($urandom); cnt0 = 10'($urandom); jump0 = 15'($urandom);
    chk({name, "_first_valid"}, valid, 1);
    while (!fin && valid && cyc < budget) begin
      vcyc++;
      chk({name, "_addr"}, addrout, exp_q[idx]);
      chk({name, "_busy_done"}, {busy, done}, 2'b10);
      if (smode == 1)      stl = ($urandom_range(0, 3) == 0);
      else if (smode == 2) stl = (vcyc == 2 || vcyc == 3);
      else                 stl = 1'b0;
      stall = stl;
      start = poke && (vcyc == 3);
      if (poke && vcyc == 3) baseaddr = 15'($urandom);
      if (stl) stalls++;
      else begin
        idx++;
        if (idx == n) fin = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    stall = 1'b0;
    start = 1'b0;
    chk({name, "_completed"}, fin, 1);
    chk({name, "_end_done_valid_busy"}, {done, valid, busy}, 3'b100);
    chk({name, "_valid_cycles"}, vcyc, n + stalls);
    $display("walk %s: %0d addresses, %0d stall cycles, %0d valid cycles",
             name, n, stalls, vcyc);
    if (idle_after) begin
      @(negedge clk);
      chk({name, "_done_one_cycle"}, {done, valid, busy}, 3'b000);
    end
  endtask

  initial begin
    vecs[0] = '{name: "basic", base: 15'd100, c0: 10'd2, c1: 10'd1, c2: 10'd0,
                j0: 15'd1, j1: 15'd5, j2: 15'd0, n: 6,
                e: '{15'd100, 15'd101, 15'd102, 15'd107, 15'd108, 15'd109, 15'd0, 15'd0}};
    vecs[1] = '{name: "negstride", base: 15'd10, c0: 10'd1, c1: 10'd1, c2: 10'd1,
                j0: 15'd2, j1: 15'h7FFD, j2: 15'd4, n: 8,
                e: '{15'd10, 15'd12, 15'd9, 15'd11, 15'd15, 15'd17, 15'd14, 15'd16}};
    vecs[2] = '{name: "wrap", base: 15'h7FFE, c0: 10'd3, c1: 10'd0, c2: 10'd0,
                j0: 15'd1, j1: 15'd0, j2: 15'd0, n: 4,
                e: '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001, 15'd0, 15'd0, 15'd0, 15'd0}};
    vecs[3] = '{name: "single", base: 15'd42, c0: 10'd0, c1: 10'd0, c2: 10'd0,
                j0: 15'd7, j1: 15'd9, j2: 15'd11, n: 1,
                e: '{15'd42, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0}};

    // Reset with start held high: clear must win.
    clr = 1'b1; start = 1'b1; stall = 1'b0;
    baseaddr = 15'd77; cnt0 = '0; cnt1 = '0; cnt2 = '0;
    jump0 = '0; jump1 = '0; jump2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_addrout", addrout, 0);
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    clr = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_no_start", {valid, busy}, 2'b00);

    // Fixed vectors.
    for (int v = 0; v < 4; v++) begin
      load_vec(v);
      run_walk(vecs[v].name, vecs[v].base, vecs[v].c0, vecs[v].c1, vecs[v].c2,
               vecs[v].j0, vecs[v].j1, vecs[v].j2, 0, 1'b0, 1'b1);
    end

    // Stall on 2nd and 3rd valid cycles; then start pulsed mid-walk.
    load_vec(0);
    run_walk("stall", vecs[0].base, vecs[0].c0, vecs[0].c1, vecs[0].c2,
             vecs[0].j0, vecs[0].j1, vecs[0].j2, 2, 1'b0, 1'b1);
    load_vec(0);
    run_walk("poke", vecs[0].base, vecs[0].c0, vecs[0].c1, vecs[0].c2,
             vecs[0].j0, vecs[0].j1, vecs[0].j2, 0, 1'b1, 1'b1);

    // Clear asserted while the 3rd address is presented.
    baseaddr = 15'd100; cnt0 = 10'd2; cnt1 = 10'd1; cnt2 = 10'd0;
    jump0 = 15'd1; jump1 = 15'd5; jump2 = 15'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clr_addr1", addrout, 100);
    @(negedge clk);
    chk("clr_addr2", addrout, 101);
    @(negedge clk);
    chk("clr_addr3", {valid, addrout}, {1'b1, 15'd102});
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_after", {valid, busy, done, addrout}, 18'd0);
    @(negedge clk);
    chk("clr_no_done", {valid, busy, done}, 3'b000);
    $display("walk clr: abandoned at 3rd address");
    load_vec(0);
    run_walk("after_clr", vecs[0].base, vecs[0].c0, vecs[0].c1, vecs[0].c2,
             vecs[0].j0, vecs[0].j1, vecs[0].j2, 0, 1'b0, 1'b1);

    // Random walks, chained back-to-back (start in the done cycle).
    for (int r = 0; r < 12; r++) begin
      logic [14:0] b, j0, j1, j2;
      logic [9:0]  c0, c1, c2;
      b  = 15'($urandom);
      c0 = 10'($urandom_range(0, 4));
      c1 = 10'($urandom_range(0, 3));
      c2 = 10'($urandom_range(0, 3));
      j0 = 15'($urandom);
      j1 = 15'($urandom);
      j2 = 15'($urandom);
      model(b, c0, c1, c2, j0, j1, j2);
      run_walk($sformatf("rand%0d", r), b, c0, c1, c2, j0, j1, j2, 1, 1'b0, r == 11);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
